tetris_piece_queue: RTL

//  Parametrised piece generator and preview queue for the GAME_clk domain.
//  - Deals spawn-ready active_piece_t values to the game FSM on request.
//  - Draws types from a shuffled bag (default), pure random, or a fixed cycle.
//  - Holds PREVIEW_DEPTH upcoming types for the display/MCU "next" panel.

---
 rtl/tetris_pkg.sv | 47 ++++
 rtl/tetris_lfsr16.sv | 27 ++
 rtl/tetris_piece_queue.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared piece types, generator modes and spawn helper
package tetris_pkg;

    typedef enum logic [2:0] {
        PIECE_I = 3'd0,
        PIECE_O = 3'd1,
        PIECE_T = 3'd2,
        PIECE_L = 3'd3,
        PIECE_J = 3'd4,
        PIECE_S = 3'd5,
        PIECE_Z = 3'd6
    } piece_type_t;

    typedef enum logic [1:0] {
        ROT_0   = 2'd0,
        ROT_90  = 2'd1,
        ROT_180 = 2'd2,
        ROT_270 = 2'd3
    } rotation_t;

    typedef struct packed {
        piece_type_t ptype;
        rotation_t   rot;
        logic [3:0]  x;
        logic [4:0]  y;
    } active_piece_t;

    typedef enum logic [1:0] {
        GEN_BAG    = 2'd0,
        GEN_RANDOM = 2'd1,
        GEN_CYCLE  = 2'd2
    } gen_mode_t;

    localparam int NUM_PIECE_TYPES = 7;

    function automatic active_piece_t spawn_piece(input piece_type_t t,
                                                  input logic [3:0] x,
                                                  input logic [4:0] y);
        active_piece_t p;
        p.ptype = t;
        p.rot   = ROT_0;
        p.x     = x;
        p.y     = y;
        return p;
    endfunction

endpackage

// File: rtl/tetris_lfsr16.sv
// rtl/tetris_lfsr16.sv - 16-bit Galois LFSR (taps 0xB400) with entropy injection
module tetris_lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        entropy_i,
    output logic [15:0] lfsr_o
);
    logic [15:0] r_lfsr;
    logic [15:0] w_step;
    logic [15:0] w_next;

    always_comb begin
        w_step = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
        w_next = w_step ^ {15'b0, entropy_i};
        // Entropy can cancel the state to zero, which would lock the register
        if (w_next == 16'h0000) w_next = SEED;
    end

    always_ff @(posedge clk) begin
        if (reset) r_lfsr <= SEED;
        else       r_lfsr <= w_next;
    end

    assign lfsr_o = r_lfsr;
endmodule

// File: rtl/tetris_piece_queue.sv
// rtl/tetris_piece_queue.sv - piece generator feeding a head + preview shift queue
module tetris_piece_queue
    import tetris_pkg::*;
#(
    parameter int          NUM_TYPES     = NUM_PIECE_TYPES,
    parameter int          PREVIEW_DEPTH = 3,
    parameter gen_mode_t   GEN_MODE      = GEN_BAG,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1,
    parameter logic [3:0]  SPAWN_X       = 4'd3,
    parameter logic [4:0]  SPAWN_Y       = 5'd0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          entropy_i,
    input  logic                          pop_i,
    output logic                          valid_o,
    output active_piece_t                 piece_o,
    output logic [PREVIEW_DEPTH-1:0][2:0] preview_o,
    output logic [2:0]                    bag_left_o,
    output logic [15:0]                   dealt_cnt_o
);
    localparam int         QLEN      = PREVIEW_DEPTH + 1;
    localparam logic [6:0] FULL_MASK = 7'((1 << NUM_TYPES) - 1);

    typedef enum logic {S_FILL, S_READY} state_t;
    typedef struct packed {
        logic [2:0] pick;
        logic [6:0] mask;
    } draw_t;

    function automatic draw_t draw(input logic [15:0] lfsr, input logic [6:0] mask,
                                   input logic [2:0] cyc);
        logic [2:0] cand;
        logic [6:0] tmp;
        logic       found;
        int         idx;
        draw_t      d;
        cand = lfsr[2:0];
        // A third pass is only ever taken when NUM_TYPES is 2
        for (int r = 0; r < 3; r++)
            if (cand >= 3'(NUM_TYPES)) cand = cand - 3'(NUM_TYPES);
        d.pick = cand;
        d.mask = mask;
        found  = 1'b0;
        if (GEN_MODE == GEN_CYCLE) begin
            d.pick = cyc;
        end else if (GEN_MODE == GEN_BAG) begin
            for (int k = 0; k < NUM_TYPES; k++) begin
                idx = int'(cand) + k;
                if (idx >= NUM_TYPES) idx = idx - NUM_TYPES;
                tmp = mask >> idx;
                if (!found && tmp[0]) begin
                    found  = 1'b1;
                    d.pick = 3'(idx);
                end
            end
            d.mask = mask & ~(7'd1 << d.pick);
            if (d.mask == 7'd0) d.mask = FULL_MASK;
        end
        return d;
    endfunction

    function automatic logic [2:0] popcount(input logic [6:0] m);
        logic [2:0] cnt;
        logic [6:0] tmp;
        cnt = 3'd0;
        for (int i = 0; i < 7; i++) begin
            tmp = m >> i;
            cnt = cnt + {2'b00, tmp[0]};
        end
        return cnt;
    endfunction

    logic [15:0]   w_lfsr;
    draw_t         w_draw;
    logic          w_take;

    state_t        r_state;
    logic [2:0]    r_count;
    logic [2:0]    r_q [QLEN];
    logic [6:0]    r_mask;
    logic [2:0]    r_cyc;
    logic          r_valid;
    active_piece_t r_piece;
    logic [15:0]   r_dealt;
    logic [2:0]    r_bag_left;

    tetris_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk       (clk),
        .reset     (reset),
        .entropy_i (entropy_i),
        .lfsr_o    (w_lfsr)
    );

    always_comb begin
        w_draw = draw(w_lfsr, r_mask, r_cyc);
        w_take = (r_state == S_FILL) || pop_i;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_FILL;
            r_count    <= 3'd0;
            r_mask     <= FULL_MASK;
            r_cyc      <= 3'd0;
            r_valid    <= 1'b0;
            r_piece    <= '0;
            r_dealt    <= 16'd0;
            r_bag_left <= 3'd0;
            for (int i = 0; i < QLEN; i++) r_q[i] <= 3'd0;
        end else begin
            if (w_take) begin
                r_mask <= w_draw.mask;
                r_cyc  <= (r_cyc == 3'(NUM_TYPES - 1)) ? 3'd0 : r_cyc + 3'd1;
            end
            r_bag_left <= (GEN_MODE == GEN_BAG) ? popcount(w_take ? w_draw.mask : r_mask) : 3'd0;
            case (r_state)
                S_FILL: begin
                    for (int i = 0; i < QLEN; i++)
                        if (i == int'(r_count)) r_q[i] <= w_draw.pick;
                    if (r_count == 3'd0)
                        r_piece <= spawn_piece(piece_type_t'(w_draw.pick), SPAWN_X, SPAWN_Y);
                    r_count <= r_count + 3'd1;
                    if (r_count == 3'(QLEN - 1)) begin
                        r_state <= S_READY;
                        r_valid <= 1'b1;
                    end
                end
                S_READY: begin
                    if (pop_i) begin
                        for (int i = 0; i < QLEN - 1; i++) r_q[i] <= r_q[i+1];
                        r_q[QLEN-1] <= w_draw.pick;
                        r_piece     <= spawn_piece(piece_type_t'(r_q[1]), SPAWN_X, SPAWN_Y);
                        r_dealt     <= r_dealt + 16'd1;
                    end
                end
                default: r_state <= S_FILL;
            endcase
        end
    end

    always_comb begin
        for (int i = 0; i < PREVIEW_DEPTH; i++) preview_o[i] = r_q[i+1];
    end

    assign valid_o     = r_valid;
    assign piece_o     = r_piece;
    assign bag_left_o  = r_bag_left;
    assign dealt_cnt_o = r_dealt;
endmodule
